fifo_wptr_full: RTL and testbench

Write-side pointer and full-flag generator for the asynchronous FIFO, running in the write clock domain. It owns the binary write counter and drives the FIFO RAM write address. It publishes a registered Gray-coded write pointer for the read-domain two-flop synchronizer. It also compares against the read pointer already synchronized into this domain to produce full, almost-full, fill level and a sticky overflow flag.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_gray_ptr.sv | 32 +++
 rtl/fifo_wptr_full.sv | 79 +++++++
 tb/tb_fifo_wptr_full.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and Gray-code helpers for the async FIFO pointer blocks.
// Helpers work on 32-bit words; callers truncate to the pointer width.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 3;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray_ptr.sv
// Binary + Gray pointer register pair with increment enable.
// Shared by the write-side full logic and the read-side empty logic.
module fifo_gray_ptr
  import fifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         inc,
  output logic [W-1:0] bin,
  output logic [W-1:0] gray,
  output logic [W-1:0] bin_next,
  output logic [W-1:0] gray_next
);

  always_comb begin
    bin_next  = bin + W'(inc);
    gray_next = W'(bin2gray(32'(bin_next)));
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full / almost-full, level and sticky overflow.
// Read pointer arrives already synchronized; its lag is left uncompensated.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH:0]   i_rptr_sync,
  input  logic                  i_clr_ovf,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [ADDR_WIDTH:0]   o_wptr,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic [ADDR_WIDTH:0]   o_wr_level,
  output logic                  o_overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AFULL_THRESH);

  logic          push;
  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rptr_full;
  logic [PW-1:0] level_next;
  logic          full_next;
  logic          afull_next;
  logic          ovf_next;

  assign push = i_wr_en & ~o_full;

  fifo_gray_ptr #(
    .W (PW)
  ) u_wptr (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .inc       (push),
    .bin       (wbin),
    .gray      (wgray),
    .bin_next  (wbin_next),
    .gray_next (wgray_next)
  );

  // Full when the write pointer is one lap ahead: top two Gray bits flipped.
  always_comb begin
    rptr_full  = {~i_rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                  i_rptr_sync[ADDR_WIDTH-2:0]};
    rbin       = PW'(gray2bin(32'(i_rptr_sync)));
    full_next  = (wgray_next == rptr_full);
    level_next = wbin_next - rbin;
    afull_next = (level_next >= AF_LVL);
    ovf_next   = (i_wr_en & o_full) | (o_overflow & ~i_clr_ovf);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_full        <= 1'b0;
      o_almost_full <= 1'b0;
      o_wr_level    <= '0;
      o_overflow    <= 1'b0;
    end else begin
      o_full        <= full_next;
      o_almost_full <= afull_next;
      o_wr_level    <= level_next;
      o_overflow    <= ovf_next;
    end
  end

  assign o_waddr = wbin[ADDR_WIDTH-1:0];
  assign o_wptr  = wgray;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full at ADDR_WIDTH=3, AFULL_THRESH=6.
// Read pointer is driven from the bench's own model of the writer.
module tb_fifo_wptr_full;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] rptr_sync;
  logic       clr_ovf;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       full;
  logic       afull;
  logic [3:0] level;
  logic       ovf;

  int errs = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  fifo_wptr_full #(
    .ADDR_WIDTH   (3),
    .AFULL_THRESH (6)
  ) dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .i_wr_en       (wr_en),
    .i_rptr_sync   (rptr_sync),
    .i_clr_ovf     (clr_ovf),
    .o_waddr       (waddr),
    .o_wptr        (wptr),
    .o_full        (full),
    .o_almost_full (afull),
    .o_wr_level    (level),
    .o_overflow    (ovf)
  );

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  int exp_wptr [8] = '{1, 3, 2, 6, 7, 5, 4, 12};
  logic [3:0] mbin, md1, md2, rb, prev;

  initial begin
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    rptr_sync = 4'd0;
    clr_ovf   = 1'b0;
    #12;
    chk("rst_waddr", waddr, 0);
    chk("rst_wptr", wptr, 0);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // fill 8 slots with reader idle
    wr_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("fill_waddr", waddr, k);
      step();
      chk("fill_wptr", wptr, exp_wptr[k]);
      chk("fill_level", level, k + 1);
      chk("fill_afull", afull, (k + 1 >= 6) ? 1 : 0);
      chk("fill_full", full, (k == 7) ? 1 : 0);
    end

    // blocked writes while full
    for (int k = 0; k < 3; k++) begin
      step();
      chk("blk_wptr", wptr, 12);
      chk("blk_waddr", waddr, 0);
      chk("blk_full", full, 1);
      chk("blk_ovf", ovf, 1);
    end
    wr_en   = 1'b0;
    clr_ovf = 1'b1;
    step();
    chk("clr_ovf", ovf, 0);
    clr_ovf = 1'b0;

    // one read seen, then refill
    rptr_sync = 4'd1;
    step();
    chk("rd_full", full, 0);
    chk("rd_level", level, 7);
    chk("rd_waddr", waddr, 0);
    wr_en = 1'b1;
    step();
    chk("refill_full", full, 1);
    chk("refill_level", level, 8);
    chk("refill_wptr", wptr, 13);

    // set beats clear on a blocked write
    clr_ovf = 1'b1;
    step();
    chk("setwin_ovf", ovf, 1);
    chk("setwin_wptr", wptr, 13);
    wr_en = 1'b0;
    step();
    chk("clr2_ovf", ovf, 0);
    clr_ovf = 1'b0;

    // reader catches up: empty
    mbin      = 4'd9;
    rptr_sync = g4(mbin);
    step();
    chk("empty_level", level, 0);
    chk("empty_full", full, 0);

    // streaming with reader two writes behind
    md1   = mbin;
    md2   = mbin;
    prev  = wptr;
    wr_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rptr_sync = g4(md2);
      rb        = md2;
      step();
      md2  = md1;
      md1  = mbin;
      mbin = mbin + 4'd1;
      chk("st_full", full, 0);
      chk("st_wptr", wptr, g4(mbin));
      chk("st_waddr", waddr, mbin[2:0]);
      chk("st_level", level, 4'(mbin - rb));
      chk("st_onebit", $countones(wptr ^ prev), 1);
      prev = wptr;
    end
    wr_en = 1'b0;
    chk("st_final_wptr", wptr, g4(4'd1));

    // hold level at 5, then reset off-edge
    rptr_sync = g4(mbin - 4'd5);
    step();
    chk("pre_rst_level", level, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_waddr", waddr, 0);
    chk("arst_wptr", wptr, 0);
    chk("arst_level", level, 0);
    chk("arst_full", full, 0);
    chk("arst_afull", afull, 0);
    chk("arst_ovf", ovf, 0);
    rptr_sync = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b1;
    chk("post_waddr0", waddr, 0);
    step();
    chk("post_waddr1", waddr, 1);
    chk("post_wptr", wptr, 1);
    chk("post_level", level, 1);
    wr_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
